// File: rtl/clk_reset_sequencer.sv
// Clock bring-up sequencer: waits for MMCM lock, pulses IDELAYCTRL reset, holds user reset until ready.
// Optional LOCK_LOSS_CNT_EN adds a saturating count of RUN->WAIT_LOCK lock-loss events.
module clk_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int IDELAY_RST_CYCLES  = 16,
    parameter int RDY_TIMEOUT        = 4096,
    parameter int RELEASE_CYCLES     = 64,
    parameter int MAX_RETRIES        = 3,
    parameter int CNT_W              = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             sys_clk_lock,
    input  logic             idelay_rdy,
    input  logic             retry_req,
    output logic             idelay_rst,
    output logic             user_rst,
    output logic             ready,
    output logic             fail,
    output logic [2:0]       state,
    output logic [1:0]       retry_cnt
`ifdef LOCK_LOSS_CNT_EN
    ,
    output logic [CNT_W-1:0] lock_loss_cnt
`endif
);

    // state       | meaning
    // WAIT_LOCK   | waiting for synchronized MMCM lock
    // LOCK_STABLE | lock must hold continuously for LOCK_STABLE_CYCLES
    // IDELAY_RST  | IDELAYCTRL reset pulse of IDELAY_RST_CYCLES
    // WAIT_RDY    | waiting for IDELAYCTRL ready, timeout triggers retry
    // RELEASE     | ready seen, counting down to user reset release
    // RUN         | clocking stable, user reset released
    // FAIL        | retries exhausted, sticky until retry_req
    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_LOCK_STABLE = 3'd1,
        ST_IDELAY_RST  = 3'd2,
        ST_WAIT_RDY    = 3'd3,
        ST_RELEASE     = 3'd4,
        ST_RUN         = 3'd5,
        ST_FAIL        = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LS_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IR_LAST  = CNT_W'(IDELAY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RT_LAST  = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RL_LAST  = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]       MAX_R    = 2'(MAX_RETRIES);

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic             lock_m, lock_s, rdy_m, rdy_s;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            lock_m     <= 1'b0;
            lock_s     <= 1'b0;
            rdy_m      <= 1'b0;
            rdy_s      <= 1'b0;
            st_q       <= ST_WAIT_LOCK;
            cnt_q      <= '0;
            retry_q    <= '0;
            idelay_rst <= 1'b1;
            user_rst   <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            lock_m     <= sys_clk_lock;
            lock_s     <= lock_m;
            rdy_m      <= idelay_rdy;
            rdy_s      <= rdy_m;
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            // outputs decoded from next state so they move on the same edge as state
            idelay_rst <= (st_d == ST_WAIT_LOCK) || (st_d == ST_LOCK_STABLE) ||
                          (st_d == ST_IDELAY_RST) || (st_d == ST_FAIL);
            user_rst   <= (st_d != ST_RUN);
            ready      <= (st_d == ST_RUN);
            fail       <= (st_d == ST_FAIL);
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case (st_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) st_d = ST_LOCK_STABLE;
            end
            ST_LOCK_STABLE: begin
                if (cnt_q == LS_LAST) begin
                    st_d  = ST_IDELAY_RST;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_IDELAY_RST: begin
                if (cnt_q == IR_LAST) begin
                    st_d  = ST_WAIT_RDY;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_RDY: begin
                if (rdy_s) begin
                    st_d  = ST_RELEASE;
                    cnt_d = '0;
                end else if (cnt_q == RT_LAST) begin
                    cnt_d = '0;
                    if (retry_q < MAX_R) begin
                        st_d    = ST_IDELAY_RST;
                        retry_d = retry_q + 2'd1;
                    end else begin
                        st_d = ST_FAIL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (!rdy_s) begin
                    st_d  = ST_IDELAY_RST;
                    cnt_d = '0;
                end else if (cnt_q == RL_LAST) begin
                    st_d  = ST_RUN;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!rdy_s) begin
                    st_d    = ST_IDELAY_RST;
                    retry_d = '0;
                end
            end
            ST_FAIL: begin
                cnt_d = '0;
                if (retry_req) begin
                    st_d    = ST_WAIT_LOCK;
                    retry_d = '0;
                end
            end
            default: begin
                st_d    = ST_WAIT_LOCK;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase
        // lock loss outranks timeout and ready events; FAIL ignores lock
        if (!lock_s && (st_q != ST_WAIT_LOCK) && (st_q != ST_FAIL)) begin
            st_d    = ST_WAIT_LOCK;
            cnt_d   = '0;
            retry_d = '0;
        end
    end

    assign state     = st_q;
    assign retry_cnt = retry_q;

`ifdef LOCK_LOSS_CNT_EN
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            lock_loss_cnt <= '0;
        end else if ((st_q == ST_RUN) && (st_d == ST_WAIT_LOCK) && (lock_loss_cnt != '1)) begin
            lock_loss_cnt <= lock_loss_cnt + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Scoreboard bench for clk_reset_sequencer: a phase/age reference model predicts each output
// change (edge number and value); a monitor compares every observed output change against it.
module tb_clk_reset_sequencer;

    localparam int LSC   = 8;
    localparam int IRC   = 4;
    localparam int RT    = 16;
    localparam int RC    = 4;
    localparam int MAXR  = 2;
    localparam int CW    = 16;

    localparam int P_WL = 0, P_LS = 1, P_IR = 2, P_WR = 3, P_REL = 4, P_RUN = 5, P_FAIL = 6;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n, sys_clk_lock, idelay_rdy, retry_req;
    logic          idelay_rst, user_rst, ready, fail;
    logic [2:0]    state;
    logic [1:0]    retry_cnt;
    logic [CW-1:0] loss_w;

`ifdef LOCK_LOSS_CNT_EN
    logic [CW-1:0] lock_loss_cnt;
    assign loss_w = lock_loss_cnt;
`else
    assign loss_w = '0;
`endif

    clk_reset_sequencer #(
        .LOCK_STABLE_CYCLES(LSC),
        .IDELAY_RST_CYCLES (IRC),
        .RDY_TIMEOUT       (RT),
        .RELEASE_CYCLES    (RC),
        .MAX_RETRIES       (MAXR),
        .CNT_W             (CW)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .sys_clk_lock (sys_clk_lock),
        .idelay_rdy   (idelay_rdy),
        .retry_req    (retry_req),
        .idelay_rst   (idelay_rst),
        .user_rst     (user_rst),
        .ready        (ready),
        .fail         (fail),
        .state        (state),
        .retry_cnt    (retry_cnt)
`ifdef LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int edge_n = 0;
    always @(posedge sys_clk) edge_n <= edge_n + 1;

    typedef struct {
        int          edge_no;
        logic [24:0] vec;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // reference model: phase, cycles spent in phase, retries, lock losses, input delay lines
    int   m_phase = P_WL, m_age = 0, m_retries = 0, m_losses = 0;
    logic lk_d1 = 0, lk_d2 = 0, rd_d1 = 0, rd_d2 = 0;
    logic [24:0] m_prev_vec;

    function automatic logic [24:0] mk_vec(int ph, int rt, int ls);
        logic idl, usr, rdy, fl;
        logic [CW-1:0] lp;
        idl = (ph == P_WL) || (ph == P_LS) || (ph == P_IR) || (ph == P_FAIL);
        usr = (ph != P_RUN);
        rdy = (ph == P_RUN);
        fl  = (ph == P_FAIL);
`ifdef LOCK_LOSS_CNT_EN
        lp = CW'(ls);
`else
        lp = '0;
`endif
        return {3'(ph), idl, usr, rdy, fl, 2'(rt), lp};
    endfunction

    function automatic logic [24:0] dut_vec();
        return {state, idelay_rst, user_rst, ready, fail, retry_cnt, loss_w};
    endfunction

    task automatic model_step(input logic lk, input logic rd, input logic rq, input logic rn);
        int   nxt;
        logic ls, rs;
        exp_t e;
        if (!rn) begin
            m_phase = P_WL; m_age = 0; m_retries = 0; m_losses = 0;
            lk_d1 = 0; lk_d2 = 0; rd_d1 = 0; rd_d2 = 0;
        end else begin
            ls  = lk_d2;
            rs  = rd_d2;
            nxt = m_phase;
            if (!ls && m_phase != P_WL && m_phase != P_FAIL) begin
                if (m_phase == P_RUN && m_losses < 65535) m_losses++;
                nxt = P_WL;
                m_retries = 0;
            end else begin
                case (m_phase)
                    P_WL:   if (ls) nxt = P_LS;
                    P_LS:   if (m_age == LSC - 1) nxt = P_IR;
                    P_IR:   if (m_age == IRC - 1) nxt = P_WR;
                    P_WR: begin
                        if (rs) nxt = P_REL;
                        else if (m_age == RT - 1) begin
                            if (m_retries < MAXR) begin
                                m_retries++;
                                nxt = P_IR;
                            end else nxt = P_FAIL;
                        end
                    end
                    P_REL: begin
                        if (!rs) nxt = P_IR;
                        else if (m_age == RC - 1) nxt = P_RUN;
                    end
                    P_RUN: if (!rs) begin nxt = P_IR; m_retries = 0; end
                    P_FAIL: if (rq) begin nxt = P_WL; m_retries = 0; end
                    default: nxt = P_WL;
                endcase
            end
            m_age   = (nxt != m_phase) ? 0 : m_age + 1;
            m_phase = nxt;
            lk_d2 = lk_d1; lk_d1 = lk;
            rd_d2 = rd_d1; rd_d1 = rd;
        end
        if (mk_vec(m_phase, m_retries, m_losses) != m_prev_vec) begin
            m_prev_vec = mk_vec(m_phase, m_retries, m_losses);
            e.edge_no  = edge_n + 1;
            e.vec      = m_prev_vec;
            q.push_back(e);
        end
    endtask

    // called just after a falling edge: predicts the next rising edge, then waits it out
    task automatic step();
        model_step(sys_clk_lock, idelay_rdy, retry_req, sys_rst_n);
        @(negedge sys_clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_phase(input int p, input int budget, input string nm);
        int n = 0;
        while (m_phase != p && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (m_phase != p) begin
            errors++;
            $display("FAIL %s: phase %0d after %0d cycles, wanted %0d", nm, m_phase, n, p);
        end
    endtask

    // monitor: every change of DUT outputs must match the next predicted change
    initial begin
        logic [24:0] prev, cur;
        exp_t e;
        @(negedge sys_clk);
        @(negedge sys_clk);
        cur = dut_vec();
        checks++;
        if (cur !== mk_vec(P_WL, 0, 0)) begin
            errors++;
            $display("FAIL reset_state: got %h wanted %h", cur, mk_vec(P_WL, 0, 0));
        end
        prev = cur;
        forever begin
            @(negedge sys_clk);
            cur = dut_vec();
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change at edge %0d: got %h, nothing predicted", edge_n, cur);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.vec || e.edge_no != edge_n) begin
                        errors++;
                        $display("FAIL output_change: got %h at edge %0d, wanted %h at edge %0d",
                                 cur, edge_n, e.vec, e.edge_no);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        m_prev_vec   = mk_vec(P_WL, 0, 0);
        sys_rst_n    = 1'b0;
        sys_clk_lock = 1'b0;
        idelay_rdy   = 1'b0;
        retry_req    = 1'b0;
        @(negedge sys_clk);
        steps(2);
        sys_rst_n = 1'b1;

        // clean bring-up, ready 5 cycles after idelay_rst falls
        sys_clk_lock = 1'b1;
        run_until_phase(P_WR, 60, "clean_to_wait_rdy");
        steps(4);
        idelay_rdy = 1'b1;
        run_until_phase(P_RUN, 40, "clean_to_run");
        steps(5);

        // timeout then success on second attempt
        idelay_rdy = 1'b0;
        run_until_phase(P_WR, 20, "retry_to_wait_rdy");
        begin
            int n = 0;
            while (!(m_phase == P_WR && m_retries == 1) && n < 60) begin step(); n++; end
        end
        steps($urandom_range(0, 8));
        idelay_rdy = 1'b1;
        run_until_phase(P_RUN, 40, "retry_to_run");
        steps(3);

        // exhaustion to FAIL, lock ignored while failed, then retry_req
        idelay_rdy = 1'b0;
        run_until_phase(P_FAIL, 200, "exhaust_to_fail");
        for (int i = 0; i < 100; i++) begin
            sys_clk_lock = (i > 94) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
        retry_req = 1'b1;
        step();
        retry_req = 1'b0;
        steps(3);

        // lock loss in RUN: one-cycle drop
        idelay_rdy = 1'b1;
        run_until_phase(P_RUN, 80, "lockloss_to_run");
        steps(3);
        sys_clk_lock = 1'b0;
        step();
        sys_clk_lock = 1'b1;
        steps(30);

        // lock lost on the same cycle as a WAIT_RDY timeout, during second attempt
        idelay_rdy = 1'b0;
        run_until_phase(P_WR, 20, "simul_to_wait_rdy");
        begin
            int n = 0;
            while (!(m_phase == P_WR && m_retries == 1 && m_age == RT - 3) && n < 80) begin step(); n++; end
        end
        sys_clk_lock = 1'b0;
        steps(3);
        sys_clk_lock = 1'b1;

        // glitch at LOCK_STABLE count 6
        run_until_phase(P_LS, 20, "glitch_to_lock_stable");
        begin
            int n = 0;
            while (m_age != 4 && n < 10) begin step(); n++; end
        end
        sys_clk_lock = 1'b0;
        step();
        sys_clk_lock = 1'b1;
        steps(20);

        // synchronous reset in RELEASE
        idelay_rdy = 1'b1;
        run_until_phase(P_REL, 80, "rst_to_release");
        step();
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        run_until_phase(P_RUN, 60, "rst_recover_to_run");

        // random soak
        for (int i = 0; i < 3000; i++) begin
            sys_clk_lock = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 29) == 0) idelay_rdy = ~idelay_rdy;
            retry_req = ($urandom_range(0, 19) == 0);
            sys_rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        sys_rst_n    = 1'b1;
        retry_req    = 1'b0;
        sys_clk_lock = 1'b1;
        steps(4);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_changes: %0d predicted changes never seen, wanted 0", q.size());
        end
        checks++;
        if (dut_vec() !== m_prev_vec) begin
            errors++;
            $display("FAIL final_outputs: got %h wanted %h", dut_vec(), m_prev_vec);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_reset_sequencer.md
Name: clk_reset_sequencer

Overview:
Bring-up and recovery sequencer for the board clock infrastructure. It watches the system clock MMCM lock and the IDELAYCTRL ready flag. It drives the IDELAYCTRL reset and holds the fabric user reset until the clocking is stable, retrying or declaring failure on timeout. It sits beside the infrastructure instance and runs on sys_clk; its user_rst feeds all downstream datapath resets.

Parameters:
LOCK_STABLE_CYCLES, 1024, cycles lock must stay high continuously before IDELAYCTRL reset is released
IDELAY_RST_CYCLES, 16, width of the IDELAYCTRL reset pulse
RDY_TIMEOUT, 4096, cycles to wait for idelay_rdy before a retry
RELEASE_CYCLES, 64, cycles between ready detection and user reset release
MAX_RETRIES, 3, IDELAYCTRL reset retries before FAIL
CNT_W, 16, width of internal counters and the optional statistic output

Ports:
sys_clk  input  1  sole clock, all logic rising-edge
sys_rst_n  input  1  synchronous active-low reset
sys_clk_lock  input  1  MMCM lock (asynchronous, 2-flop synchronized)
idelay_rdy  input  1  IDELAYCTRL ready (asynchronous, 2-flop synchronized)
retry_req  input  1  single-cycle pulse; leaves FAIL
idelay_rst  output  1  IDELAYCTRL reset, active high
user_rst  output  1  fabric reset, active high
ready  output  1  high only in RUN
fail  output  1  high only in FAIL
state  output  3  current state encoding
retry_cnt  output  2  retries used in the current bring-up attempt

Behaviour:
- Interface: one clock (sys_clk); reset sys_rst_n is synchronous and active-low.
- Reset (sys_rst_n low at a rising edge) produces: state=WAIT_LOCK, idelay_rst=1, user_rst=1, ready=0, fail=0, retry_cnt=0. All counters and synchronizer flops are cleared.
- Synchronized inputs are lock_s and rdy_s, each 2 cycles behind its input. All decisions use only these.
- State encoding: WAIT_LOCK=0, LOCK_STABLE=1, IDELAY_RST=2, WAIT_RDY=3, RELEASE=4, RUN=5, FAIL=6.
- WAIT_LOCK: go to LOCK_STABLE when lock_s=1; the counter is cleared on entry.
- LOCK_STABLE: counter increments each cycle. When counter = LOCK_STABLE_CYCLES-1, go to IDELAY_RST.
- IDELAY_RST: stay exactly IDELAY_RST_CYCLES cycles, then go to WAIT_RDY; the counter is cleared.
- WAIT_RDY: if rdy_s=1, go to RELEASE. If the counter reaches RDY_TIMEOUT-1 with rdy_s=0:
  - retry_cnt<MAX_RETRIES: increment retry_cnt and go to IDELAY_RST.
  - otherwise: go to FAIL.
  - rdy_s=1 on the timeout cycle counts as success.
- RELEASE: after RELEASE_CYCLES cycles, go to RUN. If rdy_s drops, go to IDELAY_RST; this does not consume a retry.
- RUN: user_rst=0, ready=1. If rdy_s drops, go to IDELAY_RST; user_rst is reasserted on the same edge and retry_cnt is cleared.
- FAIL: idelay_rst=1, user_rst=1, fail=1. The state is sticky; retry_req=1 moves to WAIT_LOCK and clears retry_cnt. lock_s is ignored in FAIL.
- Output decode is registered with the state, so outputs change on the same edge as the state:
  - idelay_rst=1 in WAIT_LOCK, LOCK_STABLE, IDELAY_RST and FAIL.
  - user_rst=0 only in RUN.
- Priority:
  - lock_s=0 in any state except WAIT_LOCK or FAIL forces WAIT_LOCK on the next edge, clears counters and retry_cnt, and overrides timeout and rdy events in the same cycle.
  - sys_rst_n overrides everything.
- A lock glitch during LOCK_STABLE restarts the full LOCK_STABLE_CYCLES count.
- Counters never wrap; the parameter limits must each be ≤ 2^CNT_W.

Optional Feature:
LOCK_LOSS_CNT_EN:
- Defined: adds output lock_loss_cnt [CNT_W-1:0]. It increments by 1 on each RUN→WAIT_LOCK transition caused by lock loss, saturates at all-ones, and is cleared only by sys_rst_n.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
Bench parameters: LOCK_STABLE_CYCLES=8, IDELAY_RST_CYCLES=4, RDY_TIMEOUT=16, RELEASE_CYCLES=4, MAX_RETRIES=2.
- Clean bring-up: release reset, raise lock at cycle 0, raise idelay_rdy 5 cycles after idelay_rst falls → LOCK_STABLE lasts 8 cycles; idelay_rst is high until the end of 4 IDELAY_RST cycles; user_rst falls and ready rises exactly 4 cycles after state=RELEASE; retry_cnt=0.
- Timeout retry: hold idelay_rdy=0 for the first attempt and raise it during the second WAIT_RDY → retry_cnt=1, a second 4-cycle idelay_rst pulse is seen, then RUN.
- Exhaustion: idelay_rdy never rises → 3 idelay_rst pulses, retry_cnt=2, then FAIL with fail=1 and user_rst=1. Hold for 100 cycles, then pulse retry_req → WAIT_LOCK and retry_cnt=0.
- Lock loss in RUN: drop lock for 1 cycle → 2 cycles later state=WAIT_LOCK and user_rst=1 on the same edge; the full 8-cycle stability count restarts; with LOCK_LOSS_CNT_EN, lock_loss_cnt=1.
- Simultaneous events: in WAIT_RDY, drop lock_s on the same cycle as the timeout → WAIT_LOCK, retry_cnt=0, no FAIL. Glitch lock in LOCK_STABLE at count 6 → count restarts from 0.
- Reset mid-operation: assert sys_rst_n=0 for 1 cycle in RELEASE → all outputs take reset values on that edge; sequence restarts from WAIT_LOCK.
